// File: rtl/line_clear_ctrl_if.sv
// ---------------------------------------------------------------------------
// line_clear_ctrl_if
// Interface between the line-clear sequencer and its surroundings: the
// start/busy/done handshake and the board cell read/write ports.
//   start          request a clear pass (driven by the game controller)
//   busy, done     pass status, done pulses for one cycle at the end
//   lines_cleared  rows removed in the most recent pass
//   rd_x/rd_y      board read address, rd_data returns the cell in the same cycle
//   wr_en/wr_x/wr_y/wr_data  board write port, one cell per clock
// Modports: master = sequencer side, slave = board/game side.
// ---------------------------------------------------------------------------
interface line_clear_ctrl_if #(
    parameter int CW = 3
);
    logic          start;
    logic          busy;
    logic          done;
    logic [4:0]    lines_cleared;
    logic [3:0]    rd_x;
    logic [4:0]    rd_y;
    logic [CW-1:0] rd_data;
    logic          wr_en;
    logic [3:0]    wr_x;
    logic [4:0]    wr_y;
    logic [CW-1:0] wr_data;

    modport master (
        input  start, rd_data,
        output busy, done, lines_cleared, rd_x, rd_y, wr_en, wr_x, wr_y, wr_data
    );

    modport slave (
        output start, rd_data,
        input  busy, done, lines_cleared, rd_x, rd_y, wr_en, wr_x, wr_y, wr_data
    );
endinterface

// File: rtl/line_clear_ctrl.sv
// ---------------------------------------------------------------------------
// line_clear_ctrl
// Tetris line-clear sequencer. After a piece locks it scans the board rows
// bottom-up one cell per clock, and for every full row it copies all rows
// above it down by one, blanks row 0 and re-tests the same row. At the end it
// pulses done and reports how many rows were removed.
// Ports:
//   Clock   system clock, rising edge
//   Resetn  asynchronous active-low reset; a pass in flight is abandoned
//   bus     line_clear_ctrl_if.master (handshake + board read/write ports)
// Optional build macro LINE_CLEAR_EARLY_EXIT_EN: finish the pass at the first
// completely empty row, since under gravity every row above it is empty too.
// ---------------------------------------------------------------------------
module line_clear_ctrl #(
    parameter int ROWS = 20,
    parameter int COLS = 16,
    parameter int CW   = 3
) (
    input  logic               Clock,
    input  logic               Resetn,
    line_clear_ctrl_if.master  bus
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SCAN      = 3'd1;
    localparam logic [2:0] ST_SHIFT     = 3'd2;
    localparam logic [2:0] ST_CLEAR_TOP = 3'd3;
    localparam logic [2:0] ST_DONE      = 3'd4;

    localparam logic [4:0] LAST_ROW  = 5'(ROWS - 1);
    localparam logic [3:0] LAST_COL  = 4'(COLS - 1);
    localparam logic [4:0] MAX_LINES = 5'(ROWS);

`ifdef LINE_CLEAR_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    logic [2:0] state_r;
    logic [4:0] cur_row_r;
    logic [4:0] dst_row_r;
    logic [3:0] col_r;
    logic       hole_r;     // an empty cell has been seen in the current row
    logic       any_r;      // a non-empty cell has been seen in the current row
    logic [4:0] lines_r;

    logic col_last_s;
    logic cell_empty_s;
    logic row_full_s;
    logic row_empty_s;

    // Row verdicts include the cell being read this cycle.
    always_comb begin
        col_last_s   = (col_r == LAST_COL);
        cell_empty_s = (bus.rd_data == {CW{1'b0}});
        row_full_s   = !hole_r && !cell_empty_s;
        row_empty_s  = !any_r && cell_empty_s;
    end

    // Sequencer state, row/column counters and line count.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_r   <= ST_IDLE;
            cur_row_r <= 5'd0;
            dst_row_r <= 5'd0;
            col_r     <= 4'd0;
            hole_r    <= 1'b0;
            any_r     <= 1'b0;
            lines_r   <= 5'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        cur_row_r <= LAST_ROW;
                        col_r     <= 4'd0;
                        lines_r   <= 5'd0;
                        hole_r    <= 1'b0;
                        any_r     <= 1'b0;
                        state_r   <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (col_last_s) begin
                        col_r  <= 4'd0;
                        hole_r <= 1'b0;
                        any_r  <= 1'b0;
                        if (row_full_s) begin
                            dst_row_r <= cur_row_r;
                            // Row 0 has nothing above it to shift down.
                            state_r   <= (cur_row_r == 5'd0) ? ST_CLEAR_TOP : ST_SHIFT;
                        end else if ((cur_row_r == 5'd0) || (EARLY_EXIT && row_empty_s)) begin
                            state_r <= ST_DONE;
                        end else begin
                            cur_row_r <= cur_row_r - 5'd1;
                        end
                    end else begin
                        col_r  <= col_r + 4'd1;
                        hole_r <= hole_r | cell_empty_s;
                        any_r  <= any_r | !cell_empty_s;
                    end
                end
                ST_SHIFT: begin
                    if (col_last_s) begin
                        col_r <= 4'd0;
                        if (dst_row_r == 5'd1) begin
                            state_r <= ST_CLEAR_TOP;
                        end else begin
                            dst_row_r <= dst_row_r - 5'd1;
                        end
                    end else begin
                        col_r <= col_r + 4'd1;
                    end
                end
                ST_CLEAR_TOP: begin
                    if (col_last_s) begin
                        col_r   <= 4'd0;
                        hole_r  <= 1'b0;
                        any_r   <= 1'b0;
                        lines_r <= (lines_r < MAX_LINES) ? (lines_r + 5'd1) : lines_r;
                        // Same cur_row: the row that just dropped in is re-tested.
                        state_r <= ST_SCAN;
                    end else begin
                        col_r <= col_r + 4'd1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Output decode from the state registers; write data passes the same-cycle read through.
    always_comb begin
        bus.busy          = (state_r != ST_IDLE);
        bus.done          = (state_r == ST_DONE);
        bus.lines_cleared = lines_r;
        bus.rd_x          = 4'd0;
        bus.rd_y          = 5'd0;
        bus.wr_en         = 1'b0;
        bus.wr_x          = 4'd0;
        bus.wr_y          = 5'd0;
        bus.wr_data       = {CW{1'b0}};
        case (state_r)
            ST_SCAN: begin
                bus.rd_x = col_r;
                bus.rd_y = cur_row_r;
            end
            ST_SHIFT: begin
                bus.rd_x    = col_r;
                bus.rd_y    = dst_row_r - 5'd1;
                bus.wr_en   = 1'b1;
                bus.wr_x    = col_r;
                bus.wr_y    = dst_row_r;
                bus.wr_data = bus.rd_data;
            end
            ST_CLEAR_TOP: begin
                bus.wr_en = 1'b1;
                bus.wr_x  = col_r;
                bus.wr_y  = 5'd0;
            end
            default: begin
                bus.wr_en = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_line_clear_ctrl.sv
// ---------------------------------------------------------------------------
// tb_line_clear_ctrl
// Board memory model around line_clear_ctrl. Each pass pushes the expected
// final board, line count, latency and write count into a scoreboard queue;
// a monitor pops and compares whenever done is seen.
// ---------------------------------------------------------------------------
module tb_line_clear_ctrl;

    localparam int ROWS = 20;
    localparam int COLS = 16;
    localparam int CW   = 3;
    localparam int BW   = ROWS * COLS * CW;
    localparam int RW   = COLS * CW;

`ifdef LINE_CLEAR_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef logic [BW-1:0] board_t;
    typedef logic [RW-1:0] row_t;

    typedef struct {
        board_t board;
        int     lines;
        int     cycles;
        int     writes;
    } exp_t;

    logic   Clock = 1'b0;
    logic   Resetn = 1'b0;
    board_t board;
    board_t load_img;
    logic   load_en = 1'b0;
    int     total = 0;
    int     bad = 0;
    int     since_cnt = 0;
    int     wr_cnt = 0;
    exp_t   exp_q[$];
    exp_t   mon_e;

    always #5 Clock = ~Clock;

    line_clear_ctrl_if #(.CW(CW)) bus ();

    line_clear_ctrl #(.ROWS(ROWS), .COLS(COLS), .CW(CW)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus)
    );

    function automatic logic [CW-1:0] get_cell(board_t b, int y, int x);
        if (y < ROWS && x < COLS) return b[(y*COLS + x)*CW +: CW];
        return '0;
    endfunction

    function automatic board_t set_cell(board_t b, int y, int x, logic [CW-1:0] v);
        b[(y*COLS + x)*CW +: CW] = v;
        return b;
    endfunction

    function automatic row_t get_row(board_t b, int y);
        return b[y*RW +: RW];
    endfunction

    function automatic bit row_full(row_t r);
        for (int x = 0; x < COLS; x++) if (r[x*CW +: CW] == '0) return 1'b0;
        return 1'b1;
    endfunction

    assign bus.rd_data = get_cell(board, int'(bus.rd_y), int'(bus.rd_x));

    // Board memory: bulk load from the bench, otherwise one DUT write per clock.
    always @(posedge Clock) begin
        if (load_en) board <= load_img;
        else if (bus.wr_en && int'(bus.wr_y) < ROWS && int'(bus.wr_x) < COLS)
            board[(int'(bus.wr_y)*COLS + int'(bus.wr_x))*CW +: CW] <= bus.wr_data;
    end

    // Cycles and writes since the edge that accepted start.
    always @(posedge Clock) begin
        if (bus.start && !bus.busy) begin
            since_cnt = 0;
            wr_cnt = 0;
        end else begin
            since_cnt = since_cnt + 1;
            if (bus.wr_en) wr_cnt = wr_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: full rows vanish, the rest fall to the bottom keeping order.
    // Latency follows the row-level pass: every row visit costs COLS cycles, a
    // full row at height r costs COLS*r copy cycles plus COLS blanking cycles.
    task automatic model(input board_t b, output exp_t e);
        row_t w[$];
        row_t keep[$];
        int   r;
        for (int y = 0; y < ROWS; y++) begin
            w.push_back(get_row(b, y));
            if (!row_full(get_row(b, y))) keep.push_back(get_row(b, y));
        end
        e.board = '0;
        for (int i = 0; i < keep.size(); i++)
            e.board[(ROWS - keep.size() + i)*RW +: RW] = keep[i];
        e.lines = ROWS - keep.size();
        e.cycles = 0;
        e.writes = 0;
        r = ROWS - 1;
        for (int guard = 0; guard < 1000; guard++) begin
            e.cycles += COLS;
            if (row_full(w[r])) begin
                e.cycles += COLS*r + COLS;
                e.writes += COLS*r + COLS;
                w.delete(r);
                w.push_front('0);
            end else if (r == 0 || (EARLY && w[r] == '0)) begin
                break;
            end else begin
                r--;
            end
        end
    endtask

    function automatic board_t rand_board();
        board_t b = '0;
        int h = $urandom_range(0, ROWS);
        for (int y = ROWS - h; y < ROWS; y++) begin
            if ($urandom_range(0, 3) == 0) begin
                for (int x = 0; x < COLS; x++) b = set_cell(b, y, x, CW'($urandom_range(1, 7)));
            end else begin
                int hx = $urandom_range(0, COLS - 1);
                for (int x = 0; x < COLS; x++)
                    if ($urandom_range(0, 1) == 1) b = set_cell(b, y, x, CW'($urandom_range(1, 7)));
                b = set_cell(b, y, hx, '0);
                b = set_cell(b, y, (hx + 1) % COLS, CW'($urandom_range(1, 7)));
            end
        end
        return b;
    endfunction

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    always @(negedge Clock) begin
        if (Resetn && bus.done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("lines_cleared", 64'(bus.lines_cleared), 64'(mon_e.lines));
                check("latency", 64'(since_cnt), 64'(mon_e.cycles));
                check("write_count", 64'(wr_cnt), 64'(mon_e.writes));
                check("busy_at_done", 64'(bus.busy), 64'd1);
                for (int y = 0; y < ROWS; y++)
                    check($sformatf("board_row%0d", y), 64'(get_row(board, y)), 64'(get_row(mon_e.board, y)));
            end
        end
    end

    task automatic load_board(input board_t img);
        @(negedge Clock);
        load_img = img;
        load_en = 1'b1;
        @(posedge Clock);
        #1 load_en = 1'b0;
    endtask

    task automatic run_pass(input board_t img, input int hold);
        exp_t e;
        load_board(img);
        model(img, e);
        exp_q.push_back(e);
        @(negedge Clock);
        bus.start = 1'b1;
        repeat (1 + hold) @(posedge Clock);
        #1 bus.start = 1'b0;
        for (int i = 0; i < 12000 && exp_q.size() != 0; i++) @(negedge Clock);
        check("done_seen", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        repeat (3) @(negedge Clock);
        check("lines_held", 64'(bus.lines_cleared), 64'(e.lines));
        check("idle_after", 64'({bus.busy, bus.done}), 64'd0);
    endtask

    initial begin
        board_t b;
        bus.start = 1'b0;
        board = '0;
        load_img = '0;
        #12;
        check("reset_outputs", 64'({bus.busy, bus.done, bus.lines_cleared, bus.rd_x, bus.rd_y,
                                    bus.wr_en, bus.wr_x, bus.wr_y, bus.wr_data}), 64'd0);
        @(negedge Clock);
        Resetn = 1'b1;

        // Empty board.
        run_pass('0, 0);

        // Row 19 full, row 18 has colour 1 at x=0..3.
        b = '0;
        for (int x = 0; x < COLS; x++) b = set_cell(b, 19, x, 3'd4);
        for (int x = 0; x < 4; x++) b = set_cell(b, 18, x, 3'd1);
        run_pass(b, 0);

        // Rows 18/19 full of colour 2, one cell above; start held while busy.
        b = '0;
        for (int x = 0; x < COLS; x++) begin
            b = set_cell(b, 19, x, 3'd2);
            b = set_cell(b, 18, x, 3'd2);
        end
        b = set_cell(b, 17, 5, 3'd3);
        run_pass(b, 3);

        // Only row 0 full; all others miss x=0.
        b = '0;
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++)
                if (y == 0) b = set_cell(b, y, x, 3'd6);
                else if (x != 0) b = set_cell(b, y, x, 3'd1);
        run_pass(b, 0);

        for (int n = 0; n < 8; n++) run_pass(rand_board(), $urandom_range(0, 2));

        // Start held while busy, then reset in the middle of a shift.
        b = '0;
        for (int y = 15; y < ROWS; y++)
            for (int x = 0; x < COLS; x++) b = set_cell(b, y, x, CW'(y - 12));
        load_board(b);
        @(negedge Clock);
        bus.start = 1'b1;
        repeat (4) @(posedge Clock);
        #1 bus.start = 1'b0;
        for (int i = 0; i < 2000 && !bus.wr_en; i++) @(negedge Clock);
        check("reached_shift", 64'(bus.wr_en), 64'd1);
        #2 Resetn = 1'b0;
        #1;
        check("async_reset_outputs", 64'({bus.busy, bus.done, bus.lines_cleared, bus.rd_x, bus.rd_y,
                                          bus.wr_en, bus.wr_x, bus.wr_y, bus.wr_data}), 64'd0);
        exp_q.delete();
        @(negedge Clock);
        @(negedge Clock);
        Resetn = 1'b1;
        @(negedge Clock);
        check("idle_after_reset", 64'(bus.busy), 64'd0);
        // Fresh pass on whatever partly shifted board the reset left behind.
        b = board;
        run_pass(b, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
